// File: rtl/display_scan.sv
// Six-digit common-anode scanner: walks one digit slot per prescaler period and
// latches digits and flags at frame boundaries. Blinks adjusted fields; alarm flashes all digits.
module display_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       CLK_50,
  input  logic       reset_n,
  input  logic [3:0] H1,
  input  logic [3:0] H0,
  input  logic [3:0] M1,
  input  logic [3:0] M0,
  input  logic [3:0] S1,
  input  logic [3:0] S0,
  input  logic       hr,
  input  logic       min,
  input  logic       sec,
  input  logic       alarm,
  output logic [5:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int unsigned PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [2:0] {
    SLOT_S0 = 3'd0,
    SLOT_S1 = 3'd1,
    SLOT_M0 = 3'd2,
    SLOT_M1 = 3'd3,
    SLOT_H0 = 3'd4,
    SLOT_H1 = 3'd5
  } slot_e;

  slot_e            idx_q, idx_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic             phase_q, phase_d;
  logic [5:0][3:0]  snap_q, snap_d;
  logic [3:0]       flags_q, flags_d;   // {alarm, hr, min, sec}
  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       digit;
  logic             field_on;
  logic             blank;

  always_comb begin
    tick     = (pre_q == PW'(SCAN_DIV - 1));
    pre_d    = tick ? '0 : pre_q + PW'(1);
    boundary = tick && (idx_q == SLOT_H1);

    idx_d = idx_q;
    if (tick) begin
      case (idx_q)
        SLOT_S0: idx_d = SLOT_S1;
        SLOT_S1: idx_d = SLOT_M0;
        SLOT_M0: idx_d = SLOT_M1;
        SLOT_M1: idx_d = SLOT_H0;
        SLOT_H0: idx_d = SLOT_H1;
        default: idx_d = SLOT_S0;
      endcase
    end

    snap_d  = snap_q;
    flags_d = flags_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (boundary) begin
      snap_d  = {H1, H0, M1, M0, S1, S0};
      flags_d = {alarm, hr, min, sec};
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end

    // Output stage looks at the current slot/snapshot/phase; result lands one cycle later.
    digit    = 4'hA;
    field_on = 1'b0;
    case (idx_q)
      SLOT_S0: begin digit = snap_q[0]; field_on = flags_q[0]; end
      SLOT_S1: begin digit = snap_q[1]; field_on = flags_q[0]; end
      SLOT_M0: begin digit = snap_q[2]; field_on = flags_q[1]; end
      SLOT_M1: begin digit = snap_q[3]; field_on = flags_q[1]; end
      SLOT_H0: begin digit = snap_q[4]; field_on = flags_q[2]; end
      SLOT_H1: begin digit = snap_q[5]; field_on = flags_q[2]; end
      default: begin digit = 4'hA;      field_on = 1'b0;       end
    endcase
    blank = phase_q && (flags_q[3] || field_on);

    case (digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
    if (blank) seg_d = '1;

    an_d = ~(6'b000001 << idx_q);
    dp_d = !(((idx_q == SLOT_M0) || (idx_q == SLOT_H0)) && !blank);
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      idx_q   <= SLOT_S0;
      frame_q <= '0;
      phase_q <= 1'b0;
      snap_q  <= {6{4'hA}};
      flags_q <= '0;
      an_q    <= '1;
      seg_q   <= '1;
      dp_q    <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      flags_q <= flags_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_display_scan.sv
// Randomized scoreboard bench for display_scan: expected scan outputs are derived
// from elapsed cycles since reset release and the inputs seen at each frame boundary.
module tb_display_scan;

  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 6 * SD;
  localparam int NCYC  = 3000;

  logic       CLK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] H1, H0, M1, M0, S1, S0;
  logic       hr, min, sec, alarm;
  logic [5:0] AN;
  logic [6:0] SEG;
  logic       DP;

  always #5 CLK_50 = ~CLK_50;

  display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .CLK_50(CLK_50), .reset_n(reset_n),
    .H1(H1), .H0(H0), .M1(M1), .M0(M0), .S1(S1), .S0(S0),
    .hr(hr), .min(min), .sec(sec), .alarm(alarm),
    .AN(AN), .SEG(SEG), .DP(DP)
  );

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  out_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   stim_done  = 0;

  // Reference model state: active cycles since release and the frame snapshot (index = slot).
  int         c;
  logic [3:0] m_dig [0:5];
  logic       m_hr, m_min, m_sec, m_alarm;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d <= 4'd9) ? tbl[d] : 7'b1111111;
  endfunction

  function automatic out_t model_out();
    out_t o;
    int   slot, field, phase;
    bit   blank;
    slot  = (c / SD) % 6;
    phase = ((c / FRAME) / BF) % 2;
    field = slot / 2;  // 0 seconds, 1 minutes, 2 hours
    blank = (phase == 1) && (m_alarm || (field == 0 && m_sec) ||
                             (field == 1 && m_min) || (field == 2 && m_hr));
    o.an  = 6'h3F & ~(6'd1 << slot);
    o.seg = blank ? 7'h7F : seg_of(m_dig[slot]);
    o.dp  = ((slot == 2 || slot == 4) && !blank) ? 1'b0 : 1'b1;
    return o;
  endfunction

  task automatic model_reset();
    c = 0;
    for (int i = 0; i < 6; i++) m_dig[i] = 4'hA;
    m_hr = 0; m_min = 0; m_sec = 0; m_alarm = 0;
  endtask

  // Stimulus + expectation producer
  initial begin
    bit did_mid;
    out_t rst_out;
    did_mid = 0;
    rst_out = '{an: 6'h3F, seg: 7'h7F, dp: 1'b1};
    {H1, H0, M1, M0, S1, S0} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    {hr, min, sec, alarm} = 4'b0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge CLK_50);
      reset_n = (cyc >= 3);
      if (cyc == 60)  S0 = 4'd9;
      if (cyc == 150) hr = 1;
      if (cyc == 400) begin hr = 0; alarm = 1; min = 1; end
      if (cyc == 650) begin alarm = 0; min = 0; H1 = 4'hA; S1 = 4'hF; end
      if (cyc >= 800) begin
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 5))
            0: H1 = 4'($urandom_range(0, 15));
            1: H0 = 4'($urandom_range(0, 15));
            2: M1 = 4'($urandom_range(0, 15));
            3: M0 = 4'($urandom_range(0, 15));
            4: S1 = 4'($urandom_range(0, 15));
            default: S0 = 4'($urandom_range(0, 15));
          endcase
        end
        if ($urandom_range(0, 39) == 0) hr    = ~hr;
        if ($urandom_range(0, 39) == 0) min   = ~min;
        if ($urandom_range(0, 39) == 0) sec   = ~sec;
        if ($urandom_range(0, 79) == 0) alarm = ~alarm;
        if (!did_mid && cyc > 1000 && ((c / SD) % 6) == 3 && ((c / FRAME) / BF) % 2 == 1) begin
          reset_n = 0;
          did_mid = 1;
        end else if ($urandom_range(0, 599) == 0) begin
          reset_n = 0;
        end
      end
      if (!reset_n) begin
        exp_q.push_back(rst_out);
        model_reset();
      end else begin
        exp_q.push_back(model_out());
        if (((c + 1) % FRAME) == 0) begin
          m_dig   = '{S0, S1, M0, M1, H0, H1};
          m_hr    = hr;
          m_min   = min;
          m_sec   = sec;
          m_alarm = alarm;
        end
        c++;
      end
    end
    @(negedge CLK_50);
    stim_done = 1;
  end

  // Monitor: one output word per clock, compared against the queued expectation.
  initial begin
    out_t e;
    int   t;
    t = 0;
    forever begin
      @(posedge CLK_50);
      #1;
      t++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if (AN !== e.an || SEG !== e.seg || DP !== e.dp) begin
          mismatched++;
          $display("FAIL scan_out t=%0d: got AN=%h SEG=%b DP=%b, expected AN=%h SEG=%b DP=%b",
                   t, AN, SEG, DP, e.an, e.seg, e.dp);
        end
      end
      if (stim_done && exp_q.size() == 0) break;
      if (t > NCYC + 50) begin
        mismatched++;
        $display("FAIL watchdog: got %0d cycles, expected at most %0d", t, NCYC + 50);
        break;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
